// File: rtl/fifo2mem_writer.sv
// Moves packets from the ingress FIFO into per-queue SRAM ring regions.
// A packet becomes visible to the read side only after its eop word is written.
// Packets are dropped when the destination is not one-hot, when the queue
// lacks room for a maximum-size packet, or when they grow past the size limit.
module fifo2mem_writer #(
    parameter int DIN_WIDTH      = 202,
    parameter int NUM_QUEUES     = 5,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int QUEUE_SIZE     = 104857,
    parameter int MAX_PKT_WORDS  = 64
) (
    input  logic                                 memclk,
    input  logic                                 memreset_n,
    input  logic [DIN_WIDTH-1:0]                 din,
    input  logic                                 din_valid,
    output logic                                 din_rd_en,
    input  logic [NUM_QUEUES-1:0]                oq,
    input  logic                                 mem_ready,
    output logic                                 mem_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0]            mem_addr,
    output logic [DIN_WIDTH-1:0]                 mem_wdata,
    input  logic                                 rd_word,
    input  logic [2:0]                           rd_queue,
    output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_words,
    output logic [NUM_QUEUES-1:0]                q_empty,
    output logic [15:0]                          drop_count
);
    localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int PW = $clog2(MAX_PKT_WORDS + 1);
    localparam int AW = MEM_ADDR_WIDTH;

    typedef logic [AW-1:0] addr_t;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    // First SRAM word of a queue's region.
    function automatic addr_t region_base(input int q);
        region_base = addr_t'(q * QUEUE_SIZE);
    endfunction

    // Pointer increment that wraps from the region end back to its base.
    function automatic addr_t next_ptr(input addr_t ptr, input int q);
        addr_t last;
        last = region_base(q) + addr_t'(QUEUE_SIZE - 1);
        if (ptr == last) begin
            next_ptr = region_base(q);
        end else begin
            next_ptr = ptr + addr_t'(1);
        end
    endfunction

    state_t                state_q,     state_d;
    logic [QW-1:0]         cur_q_q,     cur_q_d;
    logic [PW-1:0]         pkt_cnt_q,   pkt_cnt_d;
    addr_t                 wr_ptr_q  [NUM_QUEUES];
    addr_t                 wr_ptr_d  [NUM_QUEUES];
    addr_t                 cmt_ptr_q [NUM_QUEUES];
    addr_t                 cmt_ptr_d [NUM_QUEUES];
    addr_t                 count_q   [NUM_QUEUES];
    addr_t                 count_d   [NUM_QUEUES];
    logic                  mem_wr_en_q, mem_wr_en_d;
    addr_t                 mem_addr_q,  mem_addr_d;
    logic [DIN_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [15:0]           drop_q,      drop_d;

    logic                  accept_s;
    logic                  sop_s;
    logic                  eop_s;
    logic                  start_s;
    logic                  drop_inc_s;
    logic                  onehot_s;
    logic                  room_s;
    logic [QW-1:0]         new_q_s;

    assign accept_s  = din_valid & mem_ready;
    assign din_rd_en = accept_s;
    assign sop_s     = din[1];
    assign eop_s     = din[0];

    // Next-state: packet FSM, per-queue pointers and counts, write port.
    always_comb begin
        state_d     = state_q;
        cur_q_d     = cur_q_q;
        pkt_cnt_d   = pkt_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        count_d     = count_q;
        mem_wr_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        start_s     = 1'b0;
        drop_inc_s  = 1'b0;
        room_s      = 1'b0;
        new_q_s     = {QW{1'b0}};
        for (int i = 0; i < NUM_QUEUES; i++) begin
            new_q_s = oq[i] ? QW'(i) : new_q_s;
        end
        onehot_s = (oq != {NUM_QUEUES{1'b0}}) &&
                   ((oq & (oq - NUM_QUEUES'(1))) == {NUM_QUEUES{1'b0}});

        case (state_q)
            ST_IDLE: begin
                if (accept_s && sop_s) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_WRITE: begin
                if (accept_s && sop_s) begin
                    // Missing eop: close out the previous packet as it stands.
                    cmt_ptr_d[cur_q_q] = wr_ptr_q[cur_q_q];
                    count_d[cur_q_q]   = count_q[cur_q_q] + addr_t'(pkt_cnt_q);
                    state_d            = ST_IDLE;
                    start_s            = 1'b1;
                end else if (accept_s) begin
                    mem_wr_en_d        = 1'b1;
                    mem_addr_d         = wr_ptr_q[cur_q_q];
                    mem_wdata_d        = din;
                    wr_ptr_d[cur_q_q]  = next_ptr(wr_ptr_q[cur_q_q], int'(cur_q_q));
                    if (eop_s) begin
                        cmt_ptr_d[cur_q_q] = wr_ptr_d[cur_q_q];
                        count_d[cur_q_q]   = count_q[cur_q_q] + addr_t'(pkt_cnt_q) + addr_t'(1);
                        state_d            = ST_IDLE;
                    end else if (pkt_cnt_q == PW'(MAX_PKT_WORDS - 1)) begin
                        // Oversized packet: rewind so its words are reused.
                        wr_ptr_d[cur_q_q] = cmt_ptr_q[cur_q_q];
                        drop_inc_s        = 1'b1;
                        state_d           = ST_DROP;
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + PW'(1);
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DROP: begin
                if (accept_s && eop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Admission of a new packet; room is judged after any commit above.
        if (start_s) begin
            room_s = (QUEUE_SIZE - int'(count_d[new_q_s])) >= MAX_PKT_WORDS;
            if (onehot_s && room_s) begin
                mem_wr_en_d       = 1'b1;
                mem_addr_d        = wr_ptr_d[new_q_s];
                mem_wdata_d       = din;
                wr_ptr_d[new_q_s] = next_ptr(wr_ptr_d[new_q_s], int'(new_q_s));
                cur_q_d           = new_q_s;
                pkt_cnt_d         = PW'(1);
                if (eop_s) begin
                    cmt_ptr_d[new_q_s] = wr_ptr_d[new_q_s];
                    count_d[new_q_s]   = count_d[new_q_s] + addr_t'(1);
                    state_d            = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end else begin
                drop_inc_s = 1'b1;
                state_d    = eop_s ? ST_IDLE : ST_DROP;
            end
        end else begin
            room_s = 1'b0;
        end

        // Read-side consumption, based on the count before this cycle's commit.
        if (rd_word && (int'(rd_queue) < NUM_QUEUES)) begin
            if (count_q[rd_queue] != addr_t'(0)) begin
                count_d[rd_queue] = count_d[rd_queue] - addr_t'(1);
            end else begin
                count_d[rd_queue] = count_d[rd_queue];
            end
        end else begin
            count_d = count_d;
        end

        if (drop_inc_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State, pointer, count and write-port registers.
    always_ff @(posedge memclk or negedge memreset_n) begin
        if (!memreset_n) begin
            state_q     <= ST_IDLE;
            cur_q_q     <= {QW{1'b0}};
            pkt_cnt_q   <= {PW{1'b0}};
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DIN_WIDTH{1'b0}};
            drop_q      <= 16'd0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                wr_ptr_q[i]  <= region_base(i);
                cmt_ptr_q[i] <= region_base(i);
                count_q[i]   <= {AW{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            cur_q_q     <= cur_q_d;
            pkt_cnt_q   <= pkt_cnt_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            drop_q      <= drop_d;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                wr_ptr_q[i]  <= wr_ptr_d[i];
                cmt_ptr_q[i] <= cmt_ptr_d[i];
                count_q[i]   <= count_d[i];
            end
        end
    end

    assign mem_wr_en  = mem_wr_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign drop_count = drop_q;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
        assign q_words[g*AW +: AW] = count_q[g];
        assign q_empty[g]          = (count_q[g] == addr_t'(0));
    end

endmodule

// File: tb/tb_fifo2mem_writer.sv
// Directed bench for fifo2mem_writer. Queue regions are shrunk to 150 words
// so wrap-around and near-full queues are reachable in a short run.
module tb_fifo2mem_writer;
    localparam int DW   = 202;
    localparam int NQ   = 5;
    localparam int AW   = 19;
    localparam int QS   = 150;
    localparam int MAXW = 64;

    logic                memclk = 1'b0;
    logic                memreset_n;
    logic [DW-1:0]       din;
    logic                din_valid;
    logic                din_rd_en;
    logic [NQ-1:0]       oq;
    logic                mem_ready;
    logic                mem_wr_en;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                rd_word;
    logic [2:0]          rd_queue;
    logic [NQ*AW-1:0]    q_words;
    logic [NQ-1:0]       q_empty;
    logic [15:0]         drop_count;

    fifo2mem_writer #(
        .DIN_WIDTH(DW), .NUM_QUEUES(NQ), .MEM_ADDR_WIDTH(AW),
        .QUEUE_SIZE(QS), .MAX_PKT_WORDS(MAXW)
    ) dut (
        .memclk(memclk), .memreset_n(memreset_n), .din(din), .din_valid(din_valid),
        .din_rd_en(din_rd_en), .oq(oq), .mem_ready(mem_ready), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rd_word(rd_word), .rd_queue(rd_queue),
        .q_words(q_words), .q_empty(q_empty), .drop_count(drop_count)
    );

    always #5 memclk = ~memclk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;
    logic [31:0] seq;
    int          obs[$];

    // Behavioural model: offsets within each region, committed counts, drops.
    int          m_wr[NQ];
    int          m_cmt[NQ];
    int          m_cnt[NQ];
    int          m_drop;
    bit          m_in_pkt;
    bit          m_dropping;
    int          m_pq;
    int          m_pw;
    bit          exp_wr_en;
    int          exp_addr;
    logic [DW-1:0] exp_wdata;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) begin
            m_wr[i] = 0; m_cmt[i] = 0; m_cnt[i] = 0;
        end
        m_drop = 0; m_in_pkt = 1'b0; m_dropping = 1'b0; m_pq = 0; m_pw = 0;
        exp_wr_en = 1'b0; exp_addr = 0; exp_wdata = '0;
    endtask

    task automatic bump_drop();
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic model_write(input logic [DW-1:0] w, input bit eop);
        exp_wr_en = 1'b1;
        exp_addr  = m_pq * QS + m_wr[m_pq];
        exp_wdata = w;
        m_wr[m_pq] = (m_wr[m_pq] + 1) % QS;
        m_pw++;
        if (eop) begin
            m_cmt[m_pq] = m_wr[m_pq];
            m_cnt[m_pq] += m_pw;
            m_in_pkt = 1'b0;
        end else if (m_pw == MAXW) begin
            m_wr[m_pq] = m_cmt[m_pq];
            bump_drop();
            m_in_pkt = 1'b0;
            m_dropping = 1'b1;
        end
    endtask

    task automatic model_word(input logic [DW-1:0] w, input logic [NQ-1:0] o);
        int q;
        bit sop;
        bit eop;
        sop = w[1];
        eop = w[0];
        q = 0;
        for (int i = 0; i < NQ; i++) if (o[i]) q = i;
        if (m_dropping) begin
            if (eop) m_dropping = 1'b0;
        end else if (sop) begin
            if (m_in_pkt) begin
                m_cmt[m_pq] = m_wr[m_pq];
                m_cnt[m_pq] += m_pw;
                m_in_pkt = 1'b0;
            end
            if ($countones(o) != 1 || QS - m_cnt[q] < MAXW) begin
                bump_drop();
                m_dropping = !eop;
            end else begin
                m_in_pkt = 1'b1; m_pq = q; m_pw = 0;
                model_write(w, eop);
            end
        end else if (m_in_pkt) begin
            model_write(w, eop);
        end
    endtask

    // Model advances on each clock edge from the inputs presented in that cycle.
    initial begin
        bit rd_ok;
        model_reset();
        forever begin
            @(posedge memclk or negedge memreset_n);
            if (!memreset_n) begin
                model_reset();
            end else begin
                exp_wr_en = 1'b0;
                rd_ok = rd_word && (int'(rd_queue) < NQ) && (m_cnt[rd_queue] > 0);
                if (din_valid && mem_ready) model_word(din, oq);
                if (rd_ok) m_cnt[rd_queue] = m_cnt[rd_queue] - 1;
            end
        end
    end

    // Compare process: registered outputs against the model on every cycle.
    initial begin
        forever begin
            @(negedge memclk);
            if (chk_en) begin
                chk("mem_wr_en", mem_wr_en, exp_wr_en);
                if (exp_wr_en) begin
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_wdata", mem_wdata, exp_wdata);
                end
                for (int q = 0; q < NQ; q++) begin
                    chk($sformatf("q_words[%0d]", q), q_words[q*AW +: AW], m_cnt[q]);
                    chk($sformatf("q_empty[%0d]", q), q_empty[q], m_cnt[q] == 0);
                end
                chk("drop_count", drop_count, m_drop);
                if (mem_wr_en) obs.push_back(int'(mem_addr));
            end
        end
    end

    task automatic step(input bit v, input bit s, input bit e, input logic [NQ-1:0] o,
                        input bit rdy, input bit rw, input logic [2:0] rq);
        @(negedge memclk);
        seq = seq + 32'd1;
        din = {{6{seq}}, 3'b000, 5'd24, s, e};
        din_valid = v; oq = o; mem_ready = rdy; rd_word = rw; rd_queue = rq;
        #1 chk("din_rd_en", din_rd_en, v & rdy);
    endtask

    task automatic pkt(input logic [NQ-1:0] o, input int n, input bit close);
        for (int i = 0; i < n; i++) step(1'b1, i == 0, close && (i == n - 1), o, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic rd(input int q, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 3'(q));
    endtask

    task automatic chk_obs(input string nm, input int idx, input int expv);
        int act;
        act = (idx < obs.size()) ? obs[idx] : -1;
        chk(nm, act, expv);
    endtask

    function automatic int qw(input int q);
        qw = int'(q_words[q*AW +: AW]);
    endfunction

    initial begin
        memreset_n = 1'b0; din = '0; din_valid = 1'b0; oq = '0; mem_ready = 1'b0;
        rd_word = 1'b0; rd_queue = 3'd0; seq = 32'd0;
        repeat (3) @(negedge memclk);
        #1;
        chk("rst q_words", q_words, '0);
        chk("rst q_empty", q_empty, 5'b11111);
        chk("rst drop", drop_count, 16'd0);
        chk("rst wr_en", mem_wr_en, 1'b0);
        chk("rst addr", mem_addr, 19'd0);
        chk("rst wdata", mem_wdata, '0);
        chk_en = 1'b1;
        @(negedge memclk);
        memreset_n = 1'b1;

        // 3-word packet to queue 2.
        obs.delete();
        pkt(5'b00100, 3, 1'b1);
        idle(2);
        chk("q2 n", obs.size(), 3);
        chk_obs("q2 a0", 0, 300);
        chk_obs("q2 a1", 1, 301);
        chk_obs("q2 a2", 2, 302);
        chk("q2 words", qw(2), 3);
        chk("model q2", m_cnt[2], 3);

        // Not ready, then a stray non-sop word in idle.
        obs.delete();
        step(1'b1, 1'b1, 1'b0, 5'b00100, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b0, 3'd0);
        idle(2);
        chk("stray n", obs.size(), 0);

        // Drive queue 0's write pointer to 148, then a wrapping packet.
        pkt(5'b00001, 64, 1'b1);
        pkt(5'b00001, 64, 1'b1);
        idle(2);
        chk("q0 128", qw(0), 128);
        rd(0, 128);
        pkt(5'b00001, 20, 1'b1);
        rd(0, 20);
        idle(1);
        obs.delete();
        pkt(5'b00001, 4, 1'b1);
        idle(2);
        chk_obs("wrap a0", 0, 148);
        chk_obs("wrap a1", 1, 149);
        chk_obs("wrap a2", 2, 0);
        chk_obs("wrap a3", 3, 1);
        chk("wrap words", qw(0), 4);

        // Queue 1 left with 63 free words: next packet is dropped.
        pkt(5'b00010, 64, 1'b1);
        pkt(5'b00010, 23, 1'b1);
        idle(2);
        chk("q1 87", qw(1), 87);
        obs.delete();
        pkt(5'b00010, 4, 1'b1);
        idle(2);
        chk("full n", obs.size(), 0);
        chk("full drop", drop_count, 16'd1);
        chk("full q1", qw(1), 87);
        pkt(5'b00011, 2, 1'b1);
        pkt(5'b00000, 1, 1'b1);
        idle(2);
        chk("oq drop", drop_count, 16'd3);

        // Oversized packet on queue 3.
        pkt(5'b01000, 2, 1'b1);
        idle(1);
        obs.delete();
        pkt(5'b01000, 70, 1'b0);
        step(1'b1, 1'b0, 1'b1, 5'b01000, 1'b1, 1'b0, 3'd0);
        idle(2);
        chk("big n", obs.size(), 64);
        chk_obs("big a0", 0, 452);
        chk_obs("big a63", 63, 515);
        chk("big q3", qw(3), 2);
        chk("big drop", drop_count, 16'd4);
        obs.delete();
        pkt(5'b01000, 3, 1'b1);
        idle(2);
        chk_obs("after big a0", 0, 452);
        chk("after big q3", qw(3), 5);

        // Commit and read on the same queue in one cycle; reads of empty queues.
        pkt(5'b10000, 1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 5'b10000, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 5'b10000, 1'b1, 1'b1, 3'd4);
        idle(2);
        chk("net q4", qw(4), 2);
        rd(2, 4);
        rd(7, 1);
        idle(1);
        chk("empty q2", qw(2), 0);
        chk("empty flag q2", q_empty[2], 1'b1);

        // New sop while a packet is open on the same queue.
        obs.delete();
        step(1'b1, 1'b1, 1'b0, 5'b00100, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 5'b00100, 1'b1, 1'b0, 3'd0);
        idle(2);
        chk_obs("resop a0", 0, 303);
        chk_obs("resop a2", 2, 305);
        chk("resop q2", qw(2), 3);

        // Reset in the middle of a packet.
        pkt(5'b00001, 2, 1'b0);
        @(negedge memclk);
        din_valid = 1'b0;
        #1 memreset_n = 1'b0;
        #2;
        chk("mid rst q_words", q_words, '0);
        chk("mid rst q_empty", q_empty, 5'b11111);
        chk("mid rst drop", drop_count, 16'd0);
        chk("mid rst addr", mem_addr, 19'd0);
        @(negedge memclk);
        memreset_n = 1'b1;
        obs.delete();
        step(1'b1, 1'b0, 1'b1, 5'b00001, 1'b1, 1'b0, 3'd0);
        idle(2);
        chk("trail n", obs.size(), 0);
        pkt(5'b00001, 2, 1'b1);
        idle(2);
        chk_obs("post rst a0", 0, 0);
        chk_obs("post rst a1", 1, 1);
        chk("post rst q0", qw(0), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo2mem_writer.md
FIFO2MEM_WRITER -- requirements
Module: fifo2mem_writer

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- DIN_WIDTH, 202, word width from the ingress async FIFO (192 data + 10 meta).
- NUM_QUEUES, 5, number of output queues.
- MEM_ADDR_WIDTH, 19, SRAM word address width.
- QUEUE_SIZE, 104857, words per queue region.
- MAX_PKT_WORDS, 64, largest legal packet in words.
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- memclk, in, 1, the single clock.
- memreset_n, in, 1, reset, asynchronous and active-low.
- din, in, DIN_WIDTH, FIFO word. Bit 0 is eop, bit 1 is sop, [6:2] is the byte count, [9:7] is reserved, [DIN_WIDTH-1:10] is data.
- din_valid, in, 1, FIFO word available.
- din_rd_en, out, 1, pop of the FIFO word; combinational.
- oq, in, NUM_QUEUES, one-hot destination; sampled only on the sop word.
- mem_ready, in, 1, SRAM accepts a write this cycle.
- mem_wr_en, out, 1, SRAM write strobe.
- mem_addr, out, MEM_ADDR_WIDTH, SRAM write address.
- mem_wdata, out, DIN_WIDTH, SRAM write data; the full word, meta included.
- rd_word, in, 1, read side consumed one word.
- rd_queue, in, 3, queue index of rd_word.
- q_words, out, NUM_QUEUES*MEM_ADDR_WIDTH, committed word count per queue; queue q in slice q.
- q_empty, out, NUM_QUEUES, committed count is zero.
- drop_count, out, 16, number of dropped packets; saturating.

Function
REQ-003 SHALL give queue q the region base q*QUEUE_SIZE to q*QUEUE_SIZE+QUEUE_SIZE-1.
REQ-004 SHALL keep a write pointer, a commit pointer and a committed count per queue.
REQ-005 SHALL implement states IDLE, WRITE and DROP.
REQ-006 SHALL assert din_rd_en = din_valid & mem_ready in every state; a word is accepted in a cycle with din_rd_en=1.
REQ-007 IDLE, accepted word without sop SHALL be discarded, state stays IDLE, no write.
REQ-008 IDLE, accepted sop word SHALL:
- drop the packet (go to DROP, drop_count+1) when oq is not one-hot, or when QUEUE_SIZE - committed < MAX_PKT_WORDS for the selected queue;
- otherwise latch the queue, write the word, and go to WRITE.
REQ-009 An accepted sop word with eop=1 SHALL be written and committed in the same cycle, and the state stays IDLE.
REQ-010 WRITE, each accepted word SHALL be written at the write pointer, and the pointer SHALL advance by 1, wrapping from region end to region base.
REQ-011 WRITE, an accepted eop word SHALL be written, then the commit pointer SHALL be set to the new write pointer, the count SHALL increase by the packet word count, and the state SHALL go to IDLE.
REQ-012 WRITE, an accepted sop word without a prior eop SHALL commit the previous packet, then be handled as in REQ-008 in the same cycle.
REQ-013 WRITE, when the packet reaches MAX_PKT_WORDS words without eop:
- the write pointer SHALL be restored to the commit pointer;
- drop_count SHALL increment;
- the state SHALL go to DROP.
REQ-014 DROP SHALL discard accepted words and return to IDLE on eop.
REQ-015 mem_wr_en, mem_addr and mem_wdata SHALL be registered, asserted exactly 1 cycle after the accepted word, one word per cycle.
REQ-016 rd_word SHALL decrement the count of rd_queue.
- If the count is 0, or rd_queue >= NUM_QUEUES, the event SHALL be ignored.
- A commit and a decrement on the same queue in the same cycle SHALL apply both (net change).
REQ-017 q_words and q_empty SHALL reflect commits and decrements 1 cycle after the event; uncommitted words SHALL never be visible.
REQ-018 drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-019 memreset_n low SHALL asynchronously force:
- state to IDLE;
- all pointers to their region base;
- all counts to 0, q_empty to all ones;
- mem_wr_en to 0, mem_addr to 0, mem_wdata to 0, drop_count to 0.
REQ-020 Reset asserted mid-packet SHALL discard the packet; the first accepted word after release SHALL be treated as in IDLE.

Verification
REQ-021 3-word packet to oq=5'b00100, mem_ready=1 -> mem_addr = 209714, 209715, 209716 on consecutive cycles; q_words[2]=3 one cycle after the eop write.
REQ-022 Queue 0 write pointer at QUEUE_SIZE-2, 4-word packet -> addresses 104855, 104856, 0, 1.
REQ-023 Queue 1 committed = QUEUE_SIZE-63, sop to queue 1 -> no mem_wr_en, drop_count=1, FIFO drained through eop.
REQ-024 70-word packet without eop, then eop -> 64 writes, no commit, q_words unchanged, drop_count+1; the next packet starts at the old commit address.
REQ-025 Commit of 2 words and rd_word on the same queue in the same cycle -> count +1; rd_word on an empty queue -> count stays 0.
REQ-026 memreset_n pulsed low after 2 words of a packet -> all q_words 0, q_empty=5'b11111; a trailing non-sop word is discarded.
